p2s_stream: RTL and testbench
=============================

Name: p2s_stream

Overview:
- Parametrised parallel-to-serial converter for the FFT datapath.
- Accepts one frame of N words of DW bits each through a valid/ready handshake.
- Emits the frame one word per cycle on a valid/ready stream, tagged with the word index and a last flag.
- Double-buffered: the next frame can be accepted while the current one drains. Optional bit-reversed output order reorders radix-2 FFT results to natural order.

Parameters:
DW, 16, word width in bits
N, 8, words per frame; power of two, N >= 2
BITREV, 0, 0 = emit words in natural order k; 1 = emit word bitrev(k) at step k (log2(N)-bit reversal)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  frame present on in_data
in_ready  out  1  block can accept a frame this cycle
in_data  in  N*DW  frame; word k = in_data[k*DW +: DW]
out_valid  out  1  out_data holds a valid word
out_ready  in  1  downstream accepts the word
out_data  out  DW  current serial word
out_idx  out  log2(N)  frame index k of the word on out_data (after any reversal)
out_last  out  1  high with the final word of a frame
busy  out  1  active or pending buffer occupied

Behaviour:
- Storage:
  - active buffer (N words), step counter cnt in 0..N-1, and a pending buffer with flag pend_full.
  - State machine: IDLE (active empty) and SHIFT (active holds a frame).
- Handshakes:
  - A frame is accepted when in_valid && in_ready.
  - A word is transferred when out_valid && out_ready.
  - in_ready = !pend_full, combinational.
- Reset (async, any cycle, including mid-frame):
  - state = IDLE, cnt = 0, pend_full = 0; both frames are discarded.
  - out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, busy = 0, in_ready = 1.
- IDLE:
  - On accept, in_data loads into active, cnt = 0, and the next state is SHIFT.
  - out_valid rises the cycle after accept (latency 1).
- SHIFT:
  - out_valid = 1.
  - sel = cnt, or bitrev(cnt) when BITREV = 1.
  - out_data = active word[sel]; out_idx = sel; out_last = (cnt == N-1).
  - On transfer with cnt < N-1, cnt increments.
  - While out_ready = 0, out_data, out_idx and out_last hold stable.
  - On accept in SHIFT, in_data loads into pending and pend_full = 1.
- End of frame (transfer with cnt == N-1), priority order:
  - If pend_full: pending moves to active, cnt = 0, pend_full = 0, state stays SHIFT. in_ready rises next cycle.
  - Else if a frame is accepted in the same cycle: it loads directly into active, cnt = 0, state stays SHIFT. No bubble.
  - Else: state goes to IDLE and out_valid drops next cycle.
- Accept with pend_full = 1 cannot occur, because in_ready is low.
- Sustained throughput is N words per N cycles with no gap between frames, provided out_ready stays high and the next frame arrives before the last word.
- busy = (state == SHIFT) || pend_full.
- in_data is sampled only on accept; it is a don't-care at all other times.
- All outputs except in_ready are registered or are muxes of registered state; there is no combinational path from in_data to out_data.

Test Plan:
- Basic natural order (DW=16, N=8, BITREV=0): reset, then accept frame {1234,5678,ABCD,CDEF,0123,7894,1987,4561} with out_ready=1.
  -> out_data 1234..4561 over 8 consecutive cycles starting 1 cycle after accept; out_idx 0..7; out_last only with 4561; then out_valid=0.
- Bit-reversed order (BITREV=1), same frame.
  -> order 1234,0123,ABCD,1987,5678,7894,CDEF,4561; out_idx 0,4,2,6,1,5,3,7.
- Backpressure: out_ready=0 for 3 cycles while ABCD is presented.
  -> ABCD, idx 2 and out_valid held stable for all 3 cycles; sequence resumes unchanged with no loss or duplication.
- Double buffering: second frame {A000..A007} offered during the first frame's 3rd word.
  -> accepted; in_ready=0 until the first frame's last transfer; A000 follows 4561 on the very next cycle; 16 words in 16 cycles.
- Third frame held on in_valid while pending is full.
  -> not accepted until in_ready rises, the cycle after pending moves to active; no frame is overwritten.
- Reset mid-operation: assert rst during word 5 with pending full.
  -> all outputs go to reset values immediately; busy=0; in_ready=1; the next accepted frame starts at idx 0.

Source files
------------

// File: rtl/p2s_stream_if.sv
// Handshake bundle for p2s_stream: one parallel frame in, one serial word stream out.
interface p2s_stream_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 8
);
  localparam int unsigned IW = $clog2(N);

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/p2s_stream.sv
// Double-buffered parallel-to-serial converter: N words in per frame, one word out per cycle,
// optionally in bit-reversed index order to undo radix-2 FFT output scrambling.
module p2s_stream #(
  parameter int unsigned DW     = 16,
  parameter int unsigned N      = 8,
  parameter int unsigned BITREV = 0
) (
  input  logic          clk,
  input  logic          rst,
  p2s_stream_if.slave   bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned FW = N * DW;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [IW-1:0] cnt;
  logic [FW-1:0] active;
  logic [FW-1:0] pend;
  logic          pend_full;

  logic          accept;
  logic          xfer;
  logic          at_last;
  logic [IW-1:0] sel;

  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    for (int i = 0; i < int'(IW); i++) r[i] = v[IW-1-i];
    return r;
  endfunction

  assign accept  = bus.in_valid && !pend_full;
  assign xfer    = (state == SHIFT) && bus.out_ready;
  assign at_last = (cnt == IW'(N - 1));
  assign sel     = (BITREV != 0) ? bitrev(cnt) : cnt;

  // Frame sequencing: active drains word by word, pending refills it at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      active    <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            active <= bus.in_data;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer && at_last) begin
            cnt <= '0;
            if (pend_full) begin
              active    <= pend;
              pend_full <= 1'b0;
            end else if (accept) begin
              active <= bus.in_data;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (xfer) cnt <= cnt + IW'(1);
            if (accept) begin
              pend      <= bus.in_data;
              pend_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are selects of registered state only; nothing passes from in_data to out_data.
  assign bus.in_ready  = !pend_full;
  assign bus.out_valid = (state == SHIFT);
  assign bus.out_data  = (state == SHIFT) ? active[32'(sel) * DW +: DW] : '0;
  assign bus.out_idx   = (state == SHIFT) ? sel : '0;
  assign bus.out_last  = (state == SHIFT) && at_last;
  assign bus.busy      = (state == SHIFT) || pend_full;
endmodule

// File: tb/tb_p2s_stream.sv
// Bench for p2s_stream: natural and bit-reversed instances share stimulus and are checked
// against a frame-queue model of the stream.
module tb_p2s_stream;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned FW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  p2s_stream_if #(.DW(DW), .N(N)) b0 ();
  p2s_stream_if #(.DW(DW), .N(N)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.in_data   = in_data;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.in_data   = in_data;
  assign b1.out_ready = out_ready;

  p2s_stream #(.DW(DW), .N(N), .BITREV(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  p2s_stream #(.DW(DW), .N(N), .BITREV(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  // Model: frames still owed downstream (head = draining frame) and the head's step.
  logic [FW-1:0] mq[$];
  int            pos = 0;
  int            vecs = 0;
  int            errs = 0;

  logic [FW-1:0] f1, fa, fb, fr;

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < int'(IW); i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input int br, input logic ir, input logic ov,
                           input logic [DW-1:0] od, input logic [IW-1:0] oi,
                           input logic ol, input logic bz);
    int            sz;
    int            idx;
    logic [FW-1:0] f;
    sz = mq.size();
    chk({nm, ".in_ready"},  32'(ir), 32'(sz < 2));
    chk({nm, ".out_valid"}, 32'(ov), 32'(sz > 0));
    chk({nm, ".busy"},      32'(bz), 32'(sz > 0));
    if (sz > 0) begin
      idx = (br != 0) ? rev(pos) : pos;
      f   = mq[0];
      chk({nm, ".out_idx"},  32'(oi), 32'(idx));
      chk({nm, ".out_data"}, 32'(od), 32'(f[idx*DW +: DW]));
      chk({nm, ".out_last"}, 32'(ol), 32'(pos == int'(N) - 1));
    end
  endtask

  task automatic check_reset(input string nm, input logic ir, input logic ov,
                             input logic [DW-1:0] od, input logic [IW-1:0] oi,
                             input logic ol, input logic bz);
    chk({nm, ".rst.in_ready"},  32'(ir), 32'd1);
    chk({nm, ".rst.out_valid"}, 32'(ov), 32'd0);
    chk({nm, ".rst.out_data"},  32'(od), 32'd0);
    chk({nm, ".rst.out_idx"},   32'(oi), 32'd0);
    chk({nm, ".rst.out_last"},  32'(ol), 32'd0);
    chk({nm, ".rst.busy"},      32'(bz), 32'd0);
  endtask

  // Check both instances at the current input setup, then advance one clock and the model.
  task automatic cycle();
    bit acc;
    bit xf;
    check_dut("nat", 0, b0.in_ready, b0.out_valid, b0.out_data, b0.out_idx, b0.out_last, b0.busy);
    check_dut("rev", 1, b1.in_ready, b1.out_valid, b1.out_data, b1.out_idx, b1.out_last, b1.busy);
    acc = in_valid && (mq.size() < 2);
    xf  = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (xf) begin
      pos++;
      if (pos == int'(N)) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(in_data);
    @(negedge clk);
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(N); k++) f[k*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  // Hold a frame on in_valid until the model says it was taken; junk in_data afterwards.
  task automatic offer(input logic [FW-1:0] f, input int maxc);
    bit a;
    in_data  = f;
    in_valid = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      a = (mq.size() < 2);
      cycle();
      if (a) begin
        in_valid = 1'b0;
        in_data  = rand_frame();
        return;
      end
    end
    in_valid = 1'b0;
    chk("offer_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 40; i++) begin
      if (mq.size() > 0 && pos == p) return;
      cycle();
    end
    chk("run_to_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (mq.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 32'(mq.size()), 32'd0);
    cycle();
  endtask

  initial begin
    f1 = {16'h4561, 16'h1987, 16'h7894, 16'h0123, 16'hCDEF, 16'hABCD, 16'h5678, 16'h1234};
    for (int k = 0; k < int'(N); k++) begin
      fa[k*DW +: DW] = 16'hA000 + 16'(k);
      fb[k*DW +: DW] = 16'hB000 + 16'(k);
    end

    // Reset values while rst is held from time zero
    #2;
    check_reset("nat", b0.in_ready, b0.out_valid, b0.out_data, b0.out_idx, b0.out_last, b0.busy);
    check_reset("rev", b1.in_ready, b1.out_valid, b1.out_data, b1.out_idx, b1.out_last, b1.busy);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Basic frame, both orders, full-rate drain
    out_ready = 1'b1;
    offer(f1, 4);
    drain();

    // Backpressure for three cycles while word 2 (ABCD in both orders) is presented
    offer(f1, 4);
    run_to(2);
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    drain();

    // Double buffering plus a third frame stalled behind the full pending slot
    offer(f1, 4);
    run_to(2);
    offer(fa, 4);
    offer(fb, 20);
    drain();

    // Reset mid-frame with pending full
    offer(f1, 4);
    run_to(2);
    offer(fa, 4);
    run_to(5);
    rst = 1'b1;
    #1;
    check_reset("nat", b0.in_ready, b0.out_valid, b0.out_data, b0.out_idx, b0.out_last, b0.busy);
    check_reset("rev", b1.in_ready, b1.out_valid, b1.out_data, b1.out_idx, b1.out_last, b1.busy);
    mq.delete();
    pos = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Fresh frame after reset starts at step 0
    fr = rand_frame();
    offer(fr, 4);
    drain();

    // Randomised traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = rand_frame();
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
